// File: rtl/backend_iteration_ctrl.sv
// Iteration sequencer for the backend core array: core reset, end collection, advance/terminate.
// Optional watchdog enabled by defining BACKEND_ITER_TIMEOUT_EN.
module backend_iteration_ctrl #(
  parameter int CORE_NUM        = 4,
  parameter int ITERATION_WIDTH = 8,
  parameter int RST_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ITERATION_WIDTH-1:0]          max_iteration,
  input  logic [CORE_NUM-1:0]                 wr_end,
  input  logic [CORE_NUM*ITERATION_WIDTH-1:0] wr_end_iteration_id,
  input  logic [CORE_NUM-1:0]                 wr_valid,
  output logic [CORE_NUM-1:0]                 core_rst,
  output logic [ITERATION_WIDTH-1:0]          iteration_id,
  output logic                                iteration_start,
  output logic                                running,
  output logic                                done,
  output logic [CORE_NUM-1:0]                 end_mask,
  output logic                                id_error,
  output logic                                timeout
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int IW = ITERATION_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [IW-1:0]       r_iteration_id, w_id_nxt;
  logic [CORE_NUM-1:0] r_end_mask, w_mask_nxt;
  logic                r_active, w_active_nxt;
  logic                r_id_error, w_id_error_nxt;
  logic                r_iteration_start, w_start_nxt;

  logic [CORE_NUM-1:0] w_end_ok;
  logic [CORE_NUM-1:0] w_mask_run;
  logic                w_end_bad;
  logic [IW:0]         w_id_inc;
  logic [IW:0]         w_limit;

`ifdef BACKEND_ITER_TIMEOUT_EN
  logic [15:0] r_wdog, w_wdog_nxt;
  logic [16:0] w_wdog_inc;
  logic        r_timeout, w_timeout_nxt;
`endif

  // An end only counts when the core reports the iteration we are currently in.
  always_comb begin
    w_end_ok = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      w_end_ok[i] = wr_end[i] &&
                    (wr_end_iteration_id[i*IW +: IW] == r_iteration_id);
    end
  end

  assign w_end_bad  = |(wr_end & ~w_end_ok);
  assign w_mask_run = r_end_mask | w_end_ok;
  assign w_id_inc   = {1'b0, r_iteration_id} + (IW+1)'(1);
  assign w_limit    = (max_iteration == '0) ? (IW+1)'(1) : {1'b0, max_iteration};
`ifdef BACKEND_ITER_TIMEOUT_EN
  assign w_wdog_inc = {1'b0, r_wdog} + 17'd1;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_id_nxt       = r_iteration_id;
    w_mask_nxt     = r_end_mask;
    w_active_nxt   = r_active;
    w_id_error_nxt = r_id_error;
    w_start_nxt    = 1'b0;
`ifdef BACKEND_ITER_TIMEOUT_EN
    w_wdog_nxt     = r_wdog;
    w_timeout_nxt  = r_timeout;
`endif
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt    = S_INIT;
          w_cnt_nxt      = CW'(RST_CYCLES - 1);
          w_id_error_nxt = 1'b0;
`ifdef BACKEND_ITER_TIMEOUT_EN
          w_timeout_nxt  = 1'b0;
`endif
        end
      end
      S_INIT: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_RUN;
          w_id_nxt     = '0;
          w_mask_nxt   = '0;
          w_active_nxt = 1'b0;
          w_start_nxt  = 1'b1;
`ifdef BACKEND_ITER_TIMEOUT_EN
          w_wdog_nxt   = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RUN: begin
        w_mask_nxt = w_mask_run;
        if (|wr_valid) w_active_nxt = 1'b1;
        if (w_end_bad) w_id_error_nxt = 1'b1;
        if (&w_mask_run) w_state_nxt = S_CHECK;
`ifdef BACKEND_ITER_TIMEOUT_EN
        if ((|wr_end) || (|wr_valid)) begin
          w_wdog_nxt = '0;
        end else if (w_wdog_inc == 17'(TIMEOUT_CYCLES)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_wdog_nxt = w_wdog_inc[15:0];
        end
`endif
      end
      S_CHECK: begin
        // A write seen here arrived after all cores ended, so it belongs to no iteration.
        if (|wr_valid) w_id_error_nxt = 1'b1;
        if (!r_active || (w_id_inc >= w_limit)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt  = S_RUN;
          w_id_nxt     = w_id_inc[IW-1:0];
          w_mask_nxt   = '0;
          w_active_nxt = 1'b0;
          w_start_nxt  = 1'b1;
`ifdef BACKEND_ITER_TIMEOUT_EN
          w_wdog_nxt   = '0;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_iteration_id    <= '0;
      r_end_mask        <= '0;
      r_active          <= 1'b0;
      r_id_error        <= 1'b0;
      r_iteration_start <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_cnt             <= w_cnt_nxt;
      r_iteration_id    <= w_id_nxt;
      r_end_mask        <= w_mask_nxt;
      r_active          <= w_active_nxt;
      r_id_error        <= w_id_error_nxt;
      r_iteration_start <= w_start_nxt;
    end
  end

`ifdef BACKEND_ITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wdog    <= w_wdog_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  // Remaining outputs are straight decodes of registered state.
  assign core_rst        = ((r_state == S_IDLE) || (r_state == S_INIT)) ? '1 : '0;
  assign iteration_id    = r_iteration_id;
  assign iteration_start = r_iteration_start;
  assign running         = (r_state == S_RUN) || (r_state == S_CHECK);
  assign done            = (r_state == S_DONE);
  assign end_mask        = r_end_mask;
  assign id_error        = r_id_error;

endmodule

// File: tb/tb_backend_iteration_ctrl.sv
// Self-checking bench for backend_iteration_ctrl: phase-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_backend_iteration_ctrl;

  localparam int CN = 4;
  localparam int IW = 8;
  localparam int RC = 4;
  localparam int TO = 20;

  localparam int P_IDLE  = 0;
  localparam int P_INIT  = 1;
  localparam int P_RUN   = 2;
  localparam int P_CHECK = 3;
  localparam int P_DONE  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start = 1'b0;
  logic [IW-1:0]     max_iteration = '0;
  logic [CN-1:0]     wr_end = '0;
  logic [CN*IW-1:0]  wr_end_iteration_id = '0;
  logic [CN-1:0]     wr_valid = '0;
  logic [CN-1:0]     core_rst;
  logic [IW-1:0]     iteration_id;
  logic              iteration_start;
  logic              running;
  logic              done;
  logic [CN-1:0]     end_mask;
  logic              id_error;
  logic              timeout;

  int nChecks = 0;
  int nPass   = 0;

  int            mPhase  = P_IDLE;
  int            mLeft   = 0;
  int            mId     = 0;
  logic [CN-1:0] mMask   = '0;
  bit            mActive = 1'b0;
  bit            mErr    = 1'b0;
  bit            mTo     = 1'b0;
  bit            mPulse  = 1'b0;
  int            mWd     = 0;

  backend_iteration_ctrl #(
    .CORE_NUM(CN), .ITERATION_WIDTH(IW), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .max_iteration(max_iteration),
    .wr_end(wr_end), .wr_end_iteration_id(wr_end_iteration_id), .wr_valid(wr_valid),
    .core_rst(core_rst), .iteration_id(iteration_id), .iteration_start(iteration_start),
    .running(running), .done(done), .end_mask(end_mask), .id_error(id_error),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: what the spec says each phase does, tracked as plain counters and masks.
  task automatic modelReset();
    mPhase = P_IDLE; mLeft = 0; mId = 0; mMask = '0; mActive = 0;
    mErr = 0; mTo = 0; mPulse = 0; mWd = 0;
  endtask

  task automatic modelStep();
    int limit;
    bit anyEvt;
    mPulse = 0;
    case (mPhase)
      P_IDLE, P_DONE: if (start) begin
        mPhase = P_INIT; mLeft = RC; mErr = 0; mTo = 0;
      end
      P_INIT: begin
        mLeft--;
        if (mLeft == 0) begin
          mPhase = P_RUN; mId = 0; mMask = '0; mActive = 0; mPulse = 1; mWd = 0;
        end
      end
      P_RUN: begin
        anyEvt = (wr_end != 0) || (wr_valid != 0);
        for (int i = 0; i < CN; i++)
          if (wr_end[i]) begin
            if (int'(wr_end_iteration_id[i*IW +: IW]) == mId) mMask[i] = 1'b1;
            else mErr = 1;
          end
        if (wr_valid != 0) mActive = 1;
        if (mMask == '1) mPhase = P_CHECK;
`ifdef BACKEND_ITER_TIMEOUT_EN
        else if (anyEvt) mWd = 0;
        else begin
          mWd++;
          if (mWd == TO) begin mTo = 1; mPhase = P_DONE; end
        end
`else
        if (anyEvt) mWd = 0;
`endif
      end
      P_CHECK: begin
        if (wr_valid != 0) mErr = 1;
        limit = (max_iteration == 0) ? 1 : int'(max_iteration);
        if (!mActive || (mId + 1 >= limit)) mPhase = P_DONE;
        else begin
          mId = (mId + 1) % (1 << IW); mMask = '0; mActive = 0; mPulse = 1;
          mPhase = P_RUN; mWd = 0;
        end
      end
      default: mPhase = P_IDLE;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) modelReset();
    else modelStep();
  end

  always @(negedge clk) begin
    checkOutput("core_rst", 32'(core_rst), (mPhase == P_IDLE || mPhase == P_INIT) ? 32'hF : 32'h0);
    checkOutput("iteration_id", 32'(iteration_id), 32'(mId));
    checkOutput("iteration_start", 32'(iteration_start), 32'(mPulse));
    checkOutput("running", 32'(running), 32'(mPhase == P_RUN || mPhase == P_CHECK));
    checkOutput("done", 32'(done), 32'(mPhase == P_DONE));
    checkOutput("end_mask", 32'(end_mask), 32'(mMask));
    checkOutput("id_error", 32'(id_error), 32'(mErr));
    checkOutput("timeout", 32'(timeout), 32'(mTo));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [CN-1:0] e, input logic [CN*IW-1:0] ids,
                               input logic [CN-1:0] v);
    wr_end = e; wr_end_iteration_id = ids; wr_valid = v;
    tick();
    wr_end = '0; wr_end_iteration_id = '0; wr_valid = '0;
  endtask

  task automatic startRun(input logic [IW-1:0] maxIt);
    int k;
    max_iteration = maxIt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (k = 0; k < 10 && !iteration_start; k++) tick();
    checkOutput("runStartReached", 32'(iteration_start), 32'h1);
  endtask

  task automatic waitDone(input int budget);
    int k;
    for (k = 0; k < budget && !done; k++) tick();
    checkOutput("doneReached", 32'(done), 32'h1);
  endtask

  function automatic logic [CN*IW-1:0] allIds(input logic [IW-1:0] id);
    return {CN{id}};
  endfunction

  initial begin
    rst = 1'b0;
    #12;
    checkOutput("resetCoreRst", 32'(core_rst), 32'hF);
    checkOutput("resetRunning", 32'({running, done, iteration_start, id_error, timeout}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) tick();

    // Start timing and three full iterations.
    max_iteration = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("initCoreRst0", 32'(core_rst), 32'hF);
    for (int k = 1; k < RC; k++) begin
      tick();
      checkOutput("initCoreRst", 32'(core_rst), 32'hF);
    end
    tick();
    checkOutput("firstRunCoreRst", 32'(core_rst), 32'h0);
    checkOutput("firstIterStart", 32'(iteration_start), 32'h1);
    checkOutput("firstIterId", 32'(iteration_id), 32'h0);
    for (int it = 0; it < 3; it++) begin
      applyStimulus('0, '0, 4'b0001);
      applyStimulus(4'hF, allIds(IW'(it)), '0);
      checkOutput("checkRunning", 32'(running), 32'h1);
      tick();
      if (it < 2) begin
        checkOutput("advanceStart", 32'(iteration_start), 32'h1);
        checkOutput("advanceId", 32'(iteration_id), 32'(it + 1));
      end else begin
        checkOutput("finalDone", 32'(done), 32'h1);
        checkOutput("finalId", 32'(iteration_id), 32'h2);
      end
    end

    // Iteration with no writes terminates the run.
    startRun(8'd3);
    applyStimulus(4'hF, allIds(8'd0), 4'b0010);
    tick();
    applyStimulus(4'hF, allIds(8'd1), '0);
    tick();
    checkOutput("idleIterDone", 32'(done), 32'h1);
    checkOutput("idleIterId", 32'(iteration_id), 32'h1);

    // Mismatched id from core 2 is rejected and flagged.
    startRun(8'd2);
    applyStimulus(4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, '0);
    checkOutput("badEndMask", 32'(end_mask), 32'h0);
    checkOutput("badEndErr", 32'(id_error), 32'h1);
    applyStimulus(4'b1011, allIds(8'd0), 4'b0001);
    checkOutput("partialMask", 32'(end_mask), 32'hB);
    applyStimulus(4'b0100, allIds(8'd0), '0);
    tick();
    checkOutput("recoverId", 32'(iteration_id), 32'h1);
    applyStimulus(4'hF, allIds(8'd1), 4'b1000);
    tick();
    checkOutput("recoverDone", 32'(done), 32'h1);
    checkOutput("errSticky", 32'(id_error), 32'h1);

    // Duplicate end and a write coinciding with the last end.
    startRun(8'd2);
    checkOutput("errClearedOnStart", 32'(id_error), 32'h0);
    applyStimulus(4'b0001, allIds(8'd0), '0);
    start = 1'b1;
    applyStimulus(4'b0001, allIds(8'd0), '0);
    start = 1'b0;
    applyStimulus(4'b0110, allIds(8'd0), '0);
    applyStimulus(4'b1000, allIds(8'd0), 4'b0100);
    tick();
    checkOutput("dupAdvanceStart", 32'(iteration_start), 32'h1);
    checkOutput("dupAdvanceId", 32'(iteration_id), 32'h1);
    checkOutput("dupNoErr", 32'(id_error), 32'h0);
    applyStimulus(4'hF, allIds(8'd1), 4'b0001);
    tick();
    checkOutput("dupDone", 32'(done), 32'h1);

    // max_iteration of zero behaves as one.
    startRun(8'd0);
    applyStimulus(4'hF, allIds(8'd0), 4'b0001);
    tick();
    checkOutput("maxZeroDone", 32'(done), 32'h1);
    checkOutput("maxZeroId", 32'(iteration_id), 32'h0);

    // Write during CHECK is flagged and not counted.
    startRun(8'd3);
    applyStimulus(4'hF, allIds(8'd0), 4'b0001);
    applyStimulus('0, '0, 4'b0010);
    checkOutput("checkWriteErr", 32'(id_error), 32'h1);
    checkOutput("checkWriteId", 32'(iteration_id), 32'h1);
    applyStimulus(4'hF, allIds(8'd1), '0);
    tick();
    checkOutput("uncountedDone", 32'(done), 32'h1);

`ifdef BACKEND_ITER_TIMEOUT_EN
    startRun(8'd3);
    applyStimulus(4'b0111, allIds(8'd0), 4'b0001);
    waitDone(TO + 10);
    checkOutput("timeoutFlag", 32'(timeout), 32'h1);
`endif

    // Asynchronous reset in the middle of RUN.
    startRun(8'd3);
    applyStimulus(4'b0011, allIds(8'd0), 4'b0001);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midResetCoreRst", 32'(core_rst), 32'hF);
    checkOutput("midResetMask", 32'(end_mask), 32'h0);
    checkOutput("midResetFlags",
                32'({running, done, iteration_start, id_error, timeout}), 32'h0);
    checkOutput("midResetId", 32'(iteration_id), 32'h0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
